isqrt_pipelined: RTL and testbench

//   Responder side of the isqrt x/y valid interface used by the formula FSMs.

---
 rtl/isqrt_if.sv | 22 ++
 rtl/isqrt_pipelined.sv | 90 +++++++++
 tb/tb_isqrt_pipelined.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/isqrt_if.sv
// Request/response bundle between an initiator FSM and the square-root unit.
// No ready signal: the responder accepts every valid request.
interface isqrt_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;

  modport master (
    output x_vld,
    output x,
    input  y_vld,
    input  y
  );

  modport slave (
    input  x_vld,
    input  x,
    output y_vld,
    output y
  );
endinterface

// File: rtl/isqrt_pipelined.sv
// Fully pipelined integer square root: y = floor(sqrt(x)).
// Restoring radix-2 digit recurrence, 16 root bits spread evenly over
// N_STAGES register stages (N_STAGES must divide 16). One request per cycle,
// latency N_STAGES, results in request order.
module isqrt_pipelined #(
  parameter int N_STAGES = 4
) (
  input  logic   clk,
  input  logic   rst,
  isqrt_if.slave bus
);

  localparam int ITERS = 16 / N_STAGES;

  // Stage boundary signals: index k is the input of stage k and the output
  // of stage k-1. The last stage only forwards valid and root, since the
  // leftover radicand bits and the final remainder are never needed.
  logic        vld_s  [N_STAGES+1];
  logic [15:0] root_s [N_STAGES+1];
  logic [31:0] rad_s  [N_STAGES];
  logic [17:0] rem_s  [N_STAGES];

  assign vld_s[0]  = bus.x_vld;
  assign root_s[0] = '0;
  assign rad_s[0]  = bus.x;
  assign rem_s[0]  = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
      logic        vld_d;
      logic        vld_q;
      logic [31:0] rad_d;
      logic [17:0] rem_d;
      logic [15:0] root_d;
      logic [15:0] root_q;

      // ITERS iterations of the restoring recurrence on this stage's inputs
      always_comb begin
        vld_d  = vld_s[gi];
        rad_d  = rad_s[gi];
        rem_d  = rem_s[gi];
        root_d = root_s[gi];
        for (int i = 0; i < ITERS; i++) begin
          // remainder never exceeds 2*root, so the top two bits shifted out
          // of the 18-bit remainder are always zero
          rem_d = {rem_d[15:0], rad_d[31:30]};
          rad_d = {rad_d[29:0], 2'b00};
          if (rem_d >= {root_d, 2'b01}) begin
            rem_d  = rem_d - {root_d, 2'b01};
            root_d = {root_d[14:0], 1'b1};
          end else begin
            root_d = {root_d[14:0], 1'b0};
          end
        end
      end

      // valid is the only reset flop; data registers load every cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= vld_d;
        end
        root_q <= root_d;
      end

      assign vld_s[gi+1]  = vld_q;
      assign root_s[gi+1] = root_q;

      if (gi < N_STAGES - 1) begin : g_carry
        logic [31:0] rad_q;
        logic [17:0] rem_q;

        // remaining radicand bits and partial remainder for the next stage
        always_ff @(posedge clk) begin
          rad_q <= rad_d;
          rem_q <= rem_d;
        end

        assign rad_s[gi+1] = rad_q;
        assign rem_s[gi+1] = rem_q;
      end
    end
  endgenerate

  assign bus.y_vld = vld_s[N_STAGES];
  assign bus.y     = root_s[N_STAGES];

endmodule

// File: tb/tb_isqrt_pipelined.sv
// Drives one request stream into five square-root units (N_STAGES = 1,2,4,8,16)
// and checks every cycle that each unit's y_vld/y match the expected result
// delayed by its latency.
module tb_isqrt_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic [15:0] exp_y;
  logic        chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference root by bitwise binary search on squares
  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(v)) r = t;
    end
    return r[15:0];
  endfunction

  // Expected-result history: entry k holds the request accepted k+1 edges ago
  // (entry 0 = most recent edge). Reset wipes every in-flight request.
  logic        hv [16];
  logic [15:0] hy [16];
  logic [31:0] hx [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) hv[i] <= 1'b0;
    end else begin
      hv[0] <= x_vld;
      hy[0] <= exp_y;
      hx[0] <= x;
      for (int i = 1; i < 16; i++) begin
        hv[i] <= hv[i-1];
        hy[i] <= hy[i-1];
        hx[i] <= hx[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dut
      localparam int L = 1 << gi;
      isqrt_if dut_bus ();
      assign dut_bus.x_vld = x_vld;
      assign dut_bus.x     = x;

      isqrt_pipelined #(.N_STAGES(L)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_bus)
      );

      // Outputs are registered, so sample on the falling edge
      always @(negedge clk) begin
        if (chk_en) begin
          check($sformatf("N%0d y_vld", L), 32'(dut_bus.y_vld), 32'(hv[L-1]));
          if (hv[L-1])
            check($sformatf("N%0d y x=%h", L, hx[L-1]), 32'(dut_bus.y), 32'(hy[L-1]));
        end
      end
    end
  endgenerate

  task automatic drive(input logic r, input logic v, input logic [31:0] xv, input logic [15:0] ey);
    @(negedge clk);
    rst   = r;
    x_vld = v;
    x     = xv;
    exp_y = ey;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  logic [31:0] dir_x [20] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF,
                              32'd2, 32'd3, 32'd4, 32'd24, 32'd25,
                              32'd99, 32'd100, 32'd65535, 32'd65536, 32'hFFFE_0001,
                              32'hFFFE_0000, 32'd999999, 32'd1000000, 32'd8, 32'd9};
  logic [15:0] dir_y [20] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'hFFFF,
                              16'd1, 16'd1, 16'd2, 16'd4, 16'd5,
                              16'd9, 16'd10, 16'd255, 16'd256, 16'hFFFF,
                              16'hFFFE, 16'd999, 16'd1000, 16'd2, 16'd3};

  initial begin
    logic [31:0] k;
    logic [31:0] rv;
    rst    = 1'b1;
    x_vld  = 1'b0;
    x      = '0;
    exp_y  = '0;
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // single requests with gaps
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, dir_x[i], dir_y[i]);
      idle(18);
    end
    // directed vectors back to back
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, dir_x[i], dir_y[i]);
    idle(18);

    // consecutive stream 0..1023
    for (int i = 0; i < 1024; i++) drive(1'b0, 1'b1, 32'(i), isqrt_ref(32'(i)));
    idle(18);

    // random operands with random request density
    for (int i = 0; i < 2000; i++) begin
      rv = $urandom;
      drive(1'b0, ($urandom_range(0, 2) != 0), rv, isqrt_ref(rv));
    end
    idle(18);

    // squares and one-below-squares, fixed edges plus random samples
    for (int i = 0; i < 200; i++) begin
      if (i == 0)      k = 32'd1;
      else if (i == 1) k = 32'd2;
      else if (i == 2) k = 32'd65535;
      else if (i == 3) k = 32'd256;
      else             k = 32'($urandom_range(1, 65535));
      drive(1'b0, 1'b1, k * k, k[15:0]);
      drive(1'b0, 1'b1, k * k - 32'd1, k[15:0] - 16'd1);
    end
    idle(18);

    // reset while requests are in flight; request during reset is ignored,
    // request on the first edge after reset is accepted
    drive(1'b0, 1'b1, 32'd100, 16'd10);
    drive(1'b0, 1'b1, 32'd200, 16'd14);
    drive(1'b0, 1'b1, 32'd300, 16'd17);
    drive(1'b1, 1'b1, 32'd400, 16'd20);
    drive(1'b0, 1'b1, 32'd144, 16'd12);
    idle(24);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
